// File: rtl/fpcvt_arbiter.sv
// Round-robin arbiter sharing one FPCVT converter (12-bit two's complement to
// sign/3-bit exponent/4-bit significand) between NUM_REQ valid/ready requesters.
module fpcvt_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [12*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [2:0]              out_E,
    output logic [3:0]              out_F,
    output logic                    out_S,
    output logic [TAG_W-1:0]        out_tag,
    output logic                    busy,
    output logic [15:0]             conv_count
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CONVERT = 2'd1;
    localparam logic [1:0] S_HOLD    = 2'd2;

    // Returns {S, E, F}; the fifth significand bit rounds, overflow bumps E, E=7 saturates.
    function automatic logic [7:0] fpcvt(input logic signed [11:0] din);
        logic        sgn;
        logic [11:0] mag;
        logic [2:0]  e;
        logic [3:0]  f;
        logic        rnd;
        logic [4:0]  fr;
        sgn = din[11];
        mag = sgn ? 12'(-din) : 12'(din);
        e   = 3'd0;
        f   = mag[3:0];
        rnd = 1'b0;
        for (int p = 4; p <= 10; p++) begin
            if (mag[p]) begin
                e   = 3'(p - 3);
                f   = mag[p -: 4];
                rnd = mag[p - 4];
            end
        end
        fr = {1'b0, f} + {4'd0, rnd};
        if (mag[11]) begin
            e = 3'd7;
            f = 4'd15;
        end else if (fr[4]) begin
            if (e == 3'd7) begin
                f = 4'd15;
            end else begin
                e = e + 3'd1;
                f = 4'd8;
            end
        end else begin
            f = fr[3:0];
        end
        return {sgn, e, f};
    endfunction

    logic [1:0]         r_state;
    logic [TAG_W-1:0]   r_ptr;
    logic [TAG_W-1:0]   r_tag;
    logic signed [11:0] r_din;
    logic [2:0]         r_out_E;
    logic [3:0]         r_out_F;
    logic               r_out_S;
    logic [TAG_W-1:0]   r_out_tag;
    logic               r_out_valid;
    logic [15:0]        r_conv_count;

    logic               w_grant_vld;
    logic [TAG_W-1:0]   w_grant;
    logic signed [11:0] w_sel;
    logic [7:0]         w_cvt;
    int                 w_best;
    int                 w_dist;

    // Grant the valid requester closest after r_ptr in circular order.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant     = '0;
        w_sel       = '0;
        w_best      = NUM_REQ;
        w_dist      = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_dist = (i + 2 * NUM_REQ - int'(r_ptr) - 1) % NUM_REQ;
            if (req_valid[i] && (w_dist < w_best)) begin
                w_best      = w_dist;
                w_grant     = TAG_W'(i);
                w_grant_vld = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant == TAG_W'(i)) w_sel = req_data[12*i +: 12];
        end
    end

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = (r_state == S_IDLE) && w_grant_vld && (w_grant == TAG_W'(i));
        end
    end

    assign w_cvt = fpcvt(r_din);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_ptr        <= TAG_W'(NUM_REQ - 1);
            r_tag        <= '0;
            r_din        <= '0;
            r_out_E      <= '0;
            r_out_F      <= '0;
            r_out_S      <= 1'b0;
            r_out_tag    <= '0;
            r_out_valid  <= 1'b0;
            r_conv_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_vld) begin
                        r_din   <= w_sel;
                        r_tag   <= w_grant;
                        r_state <= S_CONVERT;
                    end
                end
                S_CONVERT: begin
                    {r_out_S, r_out_E, r_out_F} <= w_cvt;
                    r_out_tag   <= r_tag;
                    r_out_valid <= 1'b1;
                    r_state     <= S_HOLD;
                end
                S_HOLD: begin
                    // The served requester drops to lowest priority.
                    if (out_ready) begin
                        r_out_valid  <= 1'b0;
                        r_ptr        <= r_tag;
                        r_conv_count <= r_conv_count + 16'd1;
                        r_state      <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign out_valid  = r_out_valid;
    assign out_E      = r_out_E;
    assign out_F      = r_out_F;
    assign out_S      = r_out_S;
    assign out_tag    = r_out_tag;
    assign busy       = (r_state != S_IDLE);
    assign conv_count = r_conv_count;

endmodule

// File: tb/tb_fpcvt_arbiter.sv
// Randomized bench for fpcvt_arbiter checked against a transaction-level model
// of the arbitration order, one-result-in-flight handshake and FPCVT arithmetic.
module tb_fpcvt_arbiter;

    localparam int N = 4;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [12*N-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            out_valid;
    logic            out_ready;
    logic [2:0]      out_E;
    logic [3:0]      out_F;
    logic            out_S;
    logic [1:0]      out_tag;
    logic            busy;
    logic [15:0]     conv_count;

    fpcvt_arbiter #(.NUM_REQ(N), .TAG_W(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_E(out_E), .out_F(out_F), .out_S(out_S), .out_tag(out_tag),
        .busy(busy), .conv_count(conv_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Requester-side stimulus state.
    logic [N-1:0] rv;
    logic [11:0]  rd [N];
    logic         ordy;

    // Reference model state.
    logic         m_pend;
    int           m_age;
    int           m_ptr;
    int           m_tag;
    logic [7:0]   m_sef;
    logic [15:0]  m_cnt;

    logic         acc_dut;
    int           acc_dut_tag;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Value is F * 2^E with half-up rounding of the dropped bits' top bit.
    function automatic logic [7:0] ref_cvt(input logic [11:0] d);
        int   v, mag, e, f;
        logic s;
        v   = int'($signed(d));
        s   = (v < 0);
        mag = s ? -v : v;
        if (mag == 2048) begin
            e = 7; f = 15;
        end else if (mag < 16) begin
            e = 0; f = mag;
        end else begin
            e = 0;
            while ((mag >> e) >= 16) e++;
            f = (mag + (1 << (e - 1))) >> e;
            if (f == 16) begin
                if (e == 7) f = 15;
                else begin e++; f = 8; end
            end
        end
        return {s, 3'(e), 4'(f)};
    endfunction

    function automatic int rr_pick(input int ptr, input logic [N-1:0] v);
        for (int k = 1; k <= N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic tick();
        logic [N-1:0] exp_rdy;
        int g;
        @(negedge clk);
        req_valid = rv;
        for (int i = 0; i < N; i++) req_data[12*i +: 12] = rd[i];
        out_ready = ordy;
        if (m_pend) m_age++;
        #1;
        acc_dut = (req_ready != '0);
        acc_dut_tag = -1;
        for (int i = 0; i < N; i++) if (req_ready[i]) acc_dut_tag = i;
        exp_rdy = '0;
        g = -1;
        if (!m_pend && rv != '0) begin
            g = rr_pick(m_ptr, rv);
            exp_rdy = N'(1) << g;
        end
        check("req_ready", req_ready, exp_rdy);
        check("busy", busy, m_pend);
        check("out_valid", out_valid, m_pend && (m_age >= 2));
        check("conv_count", conv_count, m_cnt);
        if (m_pend && m_age >= 2) begin
            check("out_tag", out_tag, m_tag);
            check("out_SEF", {out_S, out_E, out_F}, m_sef);
            if (ordy) begin
                m_pend = 1'b0;
                m_ptr  = m_tag;
                m_cnt  = m_cnt + 16'd1;
            end
        end
        if (g >= 0) begin
            m_pend = 1'b1;
            m_age  = 0;
            m_tag  = g;
            m_sef  = ref_cvt(rd[g]);
            rv[g]  = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst    = 1'b0;
        m_pend = 1'b0;
        m_age  = 0;
        m_ptr  = N - 1;
        m_cnt  = '0;
        check("rst_state", {busy, out_valid, out_tag, out_S, out_E, out_F}, 0);
        check("rst_cnt", conv_count, 0);
    endtask

    initial begin
        int seen;
        rst = 1'b1;
        req_valid = '0;
        req_data = '0;
        out_ready = 1'b0;
        rv = '0;
        ordy = 1'b0;
        for (int i = 0; i < N; i++) rd[i] = '0;
        m_pend = 1'b0; m_age = 0; m_ptr = N - 1; m_tag = 0; m_sef = '0; m_cnt = '0;
        repeat (2) @(posedge clk);
        do_reset();

        // Single requests with known conversion values.
        ordy = 1'b1;
        rv[0] = 1'b1; rd[0] = 12'd0;    repeat (4) tick();
        rv[2] = 1'b1; rd[2] = 12'd125;  repeat (4) tick();
        rv[1] = 1'b1; rd[1] = 12'd46;   repeat (4) tick();
        rv[3] = 1'b1; rd[3] = 12'h800;  repeat (4) tick();
        rv[0] = 1'b1; rd[0] = 12'hF83;  repeat (4) tick();

        // Fairness with every requester continuously valid.
        do_reset();
        seen = 0;
        for (int c = 0; c < 40 && seen < 6; c++) begin
            rv = '1;
            for (int i = 0; i < N; i++) rd[i] = 12'($urandom);
            ordy = 1'b1;
            tick();
            if (acc_dut) begin
                check("fair_order", acc_dut_tag, seen % N);
                seen++;
            end
        end
        check("fair_count", seen, 6);
        rv = '0;
        repeat (4) tick();

        // Backpressure while other requesters wait.
        rv[1] = 1'b1; rd[1] = 12'($urandom); ordy = 1'b0;
        repeat (2) tick();
        rv[0] = 1'b1; rv[2] = 1'b1; rv[3] = 1'b1;
        rd[0] = 12'($urandom); rd[2] = 12'($urandom); rd[3] = 12'($urandom);
        repeat (10) tick();
        ordy = 1'b1;
        repeat (12) tick();

        // Reset during CONVERT, then during HOLD.
        rv = '0;
        repeat (3) tick();
        rv[2] = 1'b1; rd[2] = 12'd300;
        tick();
        do_reset();
        rv[0] = 1'b1; rv[1] = 1'b1; rd[0] = 12'd7; rd[1] = 12'hABC;
        tick();
        ordy = 1'b0;
        repeat (2) tick();
        do_reset();
        rv[0] = 1'b1; rv[3] = 1'b1; rd[0] = 12'd2047; rd[3] = 12'd1000;
        ordy = 1'b1;
        repeat (8) tick();

        // Randomized traffic.
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!rv[i] && $urandom_range(0, 3) == 0) begin
                    rv[i] = 1'b1;
                    rd[i] = 12'($urandom);
                end
            end
            ordy = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
